// File: rtl/mips_avalon_arbiter.sv
// Avalon-MM master arbiter between the cache read-miss path and the write-buffer drain.
// One bus transaction at a time. Reads win unless the buffer is full, hazarded, or starved.
module mips_avalon_arbiter #(
  parameter int unsigned MAX_READ_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  // cache read requester
  input  logic        rd_read,
  input  logic [31:0] rd_addr,
  input  logic [3:0]  rd_byteenable,
  output logic        rd_waitrequest,
  output logic [31:0] rd_readdata,
  // write-buffer drain requester
  input  logic        wb_write,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_writedata,
  input  logic [3:0]  wb_byteenable,
  input  logic        wb_full,
  input  logic        wb_hit,
  output logic        wb_waitrequest,
  // master port
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_READ_STREAK);

  state_t     state_q, state_d;
  logic [3:0] streak_q;

  logic rd_done, wr_done, raw_hazard, force_wr;

  assign rd_done    = (state_q == S_READ)  && !avm_waitrequest;
  assign wr_done    = (state_q == S_WRITE) && !avm_waitrequest;
  // A hit only matters while there is actually a buffered write to drain.
  assign raw_hazard = wb_hit && wb_write;
  assign force_wr   = wb_write && (wb_full || wb_hit || (streak_q == STREAK_MAX));

  assign rd_readdata = avm_readdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Counts reads granted while a write waits; a write completion or an empty buffer clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          streak_q <= '0;
    else if (!wb_write || wr_done)     streak_q <= '0;
    else if (rd_done && streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
  end

  always_comb begin
    state_d        = state_q;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    rd_waitrequest = 1'b1;
    wb_waitrequest = 1'b1;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (force_wr)                     state_d = S_WRITE;
        else if (rd_read && !raw_hazard)  state_d = S_READ;
        else if (wb_write)                state_d = S_WRITE;
      end
      S_READ: begin
        avm_read       = 1'b1;
        avm_address    = rd_addr;
        avm_byteenable = rd_byteenable;
        rd_waitrequest = avm_waitrequest;
        if (!avm_waitrequest) state_d = S_IDLE;
      end
      S_WRITE: begin
        avm_write      = 1'b1;
        avm_address    = wb_addr;
        avm_writedata  = wb_writedata;
        avm_byteenable = wb_byteenable;
        wb_waitrequest = avm_waitrequest;
        if (!avm_waitrequest) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench: requester queues, a fixed-latency RAM slave, and a grant-order log.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_read;
  logic [31:0] rd_addr;
  logic [3:0]  rd_byteenable;
  logic        rd_waitrequest;
  logic [31:0] rd_readdata;
  logic        wb_write;
  logic [31:0] wb_addr;
  logic [31:0] wb_writedata;
  logic [3:0]  wb_byteenable;
  logic        wb_full;
  logic        wb_hit;
  logic        wb_waitrequest;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;

  mips_avalon_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_read(rd_read), .rd_addr(rd_addr), .rd_byteenable(rd_byteenable),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_writedata(wb_writedata),
    .wb_byteenable(wb_byteenable), .wb_full(wb_full), .wb_hit(wb_hit),
    .wb_waitrequest(wb_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wbe_t;

  wbe_t        wbq[$];
  logic [31:0] rdq[$];
  logic [31:0] mem [64];
  int          delay, wcnt, full_thr;
  int          n_chk, n_err;
  int          cyc, rd_cyc, rd_wlow, npop, last_rcyc, last_wcyc;
  logic [31:0] seq, last_rdata;

  // Slave completes after `delay` wait cycles; reads see the addressed word directly.
  assign avm_waitrequest = !((avm_read || avm_write) && (wcnt >= delay));
  assign avm_readdata    = mem[avm_address[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    rd_read       = rdq.size() != 0;
    rd_addr       = rd_read ? rdq[0] : 32'h0;
    rd_byteenable = 4'hF;
    wb_write      = wbq.size() != 0;
    wb_addr       = wb_write ? wbq[0].a  : 32'h0;
    wb_writedata  = wb_write ? wbq[0].d  : 32'h0;
    wb_byteenable = wb_write ? wbq[0].be : 4'h0;
    wb_full       = wbq.size() >= full_thr;
    wb_hit        = 1'b0;
    foreach (wbq[i])
      if (rd_read && wbq[i].a[31:2] == rd_addr[31:2]) wb_hit = 1'b1;
  endtask

  task automatic clr();
    seq = 32'h1; rd_cyc = 0; rd_wlow = 0; npop = 0; last_rcyc = 0; last_wcyc = 0;
  endtask

  // One clock: observe at the falling edge, update requesters/slave just after the rising edge.
  task automatic tick();
    logic rf, wf, pop_w, pop_r;
    int   nw;
    @(negedge clk);
    cyc++;
    chk("excl", {31'b0, avm_read & avm_write}, 32'h0);
    rf = avm_read  && !avm_waitrequest;
    wf = avm_write && !avm_waitrequest;
    if (avm_read) rd_cyc++;
    pop_r = rd_read && !rd_waitrequest;
    pop_w = !wb_waitrequest;
    if (pop_r) begin rd_wlow++; last_rdata = rd_readdata; end
    if (pop_w) npop++;
    if (rf) begin seq = {seq[30:0], 1'b0}; last_rcyc = cyc; end
    if (wf) begin
      seq = {seq[30:0], 1'b1}; last_wcyc = cyc;
      for (int b = 0; b < 4; b++)
        if (avm_byteenable[b]) mem[avm_address[7:2]][8*b +: 8] = avm_writedata[8*b +: 8];
    end
    nw = ((avm_read || avm_write) && avm_waitrequest) ? wcnt + 1 : 0;
    @(posedge clk); #1;
    wcnt = nw;
    if (pop_w && wbq.size() != 0) void'(wbq.pop_front());
    if (pop_r && rdq.size() != 0) void'(rdq.pop_front());
    drive();
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while ((rdq.size() != 0 || wbq.size() != 0 || busy) && n < bound) begin
      tick(); n++;
    end
    chk("drain", {31'b0, n < bound}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; wcnt = 0; delay = 2; full_thr = 8;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    mem[1] = 32'h1234_5678;
    clr();
    rst = 1'b1;
    drive();
    #2 rst = 1'b0;

    // reset holds the bus idle even with a pending read
    rdq.push_back(32'hBFC0_0004); drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_read", {31'b0, avm_read}, 32'h0);
    chk("rst_rd_wait",  {31'b0, rd_waitrequest}, 32'h1);
    chk("rst_wb_wait",  {31'b0, wb_waitrequest}, 32'h1);
    chk("rst_addr",     avm_address, 32'h0);
    chk("rst_busy",     {31'b0, busy}, 32'h0);

    // release: read granted on the next edge, slave delay 2
    clr(); rst = 1'b1;
    tick();
    chk("rd_entered", {31'b0, avm_read}, 32'h1);
    chk("rd_addr",    avm_address, 32'hBFC0_0004);
    run_idle(100);
    chk("rd_data",    last_rdata, 32'h1234_5678);
    chk("rd_wlow",    rd_wlow, 1);
    chk("rd_cycles",  rd_cyc, 3);
    chk("rd_seq",     seq, 32'h2);

    // simultaneous: read first, one idle cycle, then write (zero-wait slave)
    delay = 0; clr();
    rdq.push_back(32'hBFC0_0010);
    wbq.push_back('{32'hBFC0_0020, 32'hDEAD_BEEF, 4'hF});
    drive();
    run_idle(100);
    chk("sim_seq",  seq, 32'h5);
    chk("sim_gap",  last_wcyc - last_rcyc, 2);
    chk("sim_rcyc", rd_cyc, 1);
    chk("sim_rdat", last_rdata, 32'hA500_0004);
    chk("sim_mem",  mem[8], 32'hDEAD_BEEF);
    chk("sim_pop",  npop, 1);

    // full buffer: write first, then read, then remaining write
    delay = 1; full_thr = 2; clr();
    wbq.push_back('{32'hBFC0_0030, 32'h1111_2222, 4'hF});
    wbq.push_back('{32'hBFC0_0034, 32'h3333_4444, 4'h3});
    rdq.push_back(32'hBFC0_0040);
    drive();
    run_idle(100);
    chk("full_seq",  seq, 32'hD);
    chk("full_pop",  npop, 2);
    chk("full_m12",  mem[12], 32'h1111_2222);
    chk("full_m13",  mem[13], 32'hA500_4444);
    chk("full_rdat", last_rdata, 32'hA500_0010);
    full_thr = 8;

    // read-after-write hazard: the buffered write drains first
    delay = 2; clr();
    wbq.push_back('{32'hBFC0_0005, 32'h0000_0019, 4'hF});
    rdq.push_back(32'hBFC0_0005);
    drive();
    chk("raw_hit", {31'b0, wb_hit}, 32'h1);
    run_idle(100);
    chk("raw_seq",  seq, 32'h6);
    chk("raw_rdat", last_rdata, 32'h0000_0019);

    // starvation: 4 reads, forced write, streak cleared, 4 reads, write, last read
    delay = 0; clr();
    wbq.push_back('{32'h0000_0200, 32'hCAFE_0001, 4'hF});
    wbq.push_back('{32'h0000_0204, 32'hCAFE_0002, 4'hF});
    for (int i = 0; i < 9; i++) rdq.push_back(32'h0000_0300 + 32'(4 * i));
    drive();
    run_idle(200);
    chk("stv_seq", seq, 32'h842);
    chk("stv_pop", npop, 2);
    chk("stv_m0",  mem[0], 32'hCAFE_0001);

    // reset mid-write aborts without a completion
    delay = 5; clr();
    mem[16] = 32'h0;
    wbq.push_back('{32'h0000_0400, 32'h0000_0055, 4'hF});
    drive();
    tick(); tick();
    chk("mid_wr",   {31'b0, avm_write}, 32'h1);
    chk("mid_addr", avm_address, 32'h0000_0400);
    rst = 1'b0; #1;
    chk("mid_avm_wr", {31'b0, avm_write}, 32'h0);
    chk("mid_wdata",  avm_writedata, 32'h0);
    chk("mid_wb_wait", {31'b0, wb_waitrequest}, 32'h1);
    chk("mid_busy",   {31'b0, busy}, 32'h0);
    tick(); tick();
    chk("mid_nopop", npop, 0);
    chk("mid_seq",   seq, 32'h1);
    wbq.delete(); drive();
    rst = 1'b1;
    tick();
    chk("mid_idle", {31'b0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
